// File: rtl/ysyx_041514_mem_access_pkg.sv
// rtl/ysyx_041514_mem_access_pkg.sv - memory-op encodings, access decode helpers and LSU FSM states
package ysyx_041514_mem_access_pkg;

  localparam int MEMOP_LEN = 4;

  localparam logic [MEMOP_LEN-1:0] MEMOP_NONE = 4'd0;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LB   = 4'd1;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LH   = 4'd2;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LW   = 4'd3;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LD   = 4'd4;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LBU  = 4'd5;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LHU  = 4'd6;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LWU  = 4'd7;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SB   = 4'd8;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SH   = 4'd9;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SW   = 4'd10;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SD   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } lsu_state_e;

  // log2 of the access size in bytes
  function automatic logic [1:0] memop_size(input logic [MEMOP_LEN-1:0] op);
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: return 2'd0;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return 2'd1;
      MEMOP_LW, MEMOP_LWU, MEMOP_SW: return 2'd2;
      default:                       return 2'd3;
    endcase
  endfunction

  function automatic logic memop_is_store(input logic [MEMOP_LEN-1:0] op);
    return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW) || (op == MEMOP_SD);
  endfunction

  function automatic logic memop_is_signed(input logic [MEMOP_LEN-1:0] op);
    return (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW);
  endfunction

  function automatic logic memop_misaligned(input logic [MEMOP_LEN-1:0] op, input logic [2:0] off);
    case (memop_size(op))
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_041514_mem_access_if.sv
// rtl/ysyx_041514_mem_access_if.sv - data-memory request/response port between LSU and memory
interface ysyx_041514_mem_access_if #(
  parameter int XLEN = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              req_wen;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_wstrb;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/ysyx_041514_mem_align.sv
// rtl/ysyx_041514_mem_align.sv - store lane shift/strobe generation and load extraction/extension
module ysyx_041514_mem_align
  import ysyx_041514_mem_access_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic [MEMOP_LEN-1:0] i_st_op,
  input  logic [2:0]           i_st_off,
  input  logic [XLEN-1:0]      i_wdata,
  output logic [XLEN-1:0]      o_wdata,
  output logic [STRB_W-1:0]    o_wstrb,
  input  logic [MEMOP_LEN-1:0] i_ld_op,
  input  logic [2:0]           i_ld_off,
  input  logic [XLEN-1:0]      i_rdata,
  output logic [XLEN-1:0]      o_rdata
);

  logic [STRB_W-1:0] w_mask;
  logic [XLEN-1:0]   w_rsh;
  logic              w_sgn;

  // lanes shifted past the top byte fall off: misaligned stores are truncated
  always_comb begin
    w_mask = '0;
    case (memop_size(i_st_op))
      2'd0:    w_mask = STRB_W'(8'h01);
      2'd1:    w_mask = STRB_W'(8'h03);
      2'd2:    w_mask = STRB_W'(8'h0F);
      default: w_mask = STRB_W'(8'hFF);
    endcase
    o_wstrb = w_mask << i_st_off;
    o_wdata = i_wdata << {i_st_off, 3'b000};
  end

  always_comb begin
    w_rsh   = i_rdata >> {i_ld_off, 3'b000};
    w_sgn   = memop_is_signed(i_ld_op);
    o_rdata = w_rsh;
    case (memop_size(i_ld_op))
      2'd0:    o_rdata = {{(XLEN-8){w_sgn & w_rsh[7]}}, w_rsh[7:0]};
      2'd1:    o_rdata = {{(XLEN-16){w_sgn & w_rsh[15]}}, w_rsh[15:0]};
      2'd2:    o_rdata = {{(XLEN-32){w_sgn & w_rsh[31]}}, w_rsh[31:0]};
      default: o_rdata = w_rsh;
    endcase
  end

endmodule

// File: rtl/ysyx_041514_mem_access.sv
// rtl/ysyx_041514_mem_access.sv - MEM-stage load/store unit, one outstanding request at a time
// Optional misaligned-access trap: YSYX_041514_MISALIGN_TRAP_EN
module ysyx_041514_mem_access
  import ysyx_041514_mem_access_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic [MEMOP_LEN-1:0] mem_op_i,
  input  logic [XLEN-1:0]      addr_i,
  input  logic [XLEN-1:0]      wdata_i,
  output logic                 stall_req_o,
  output logic [XLEN-1:0]      rdata_o,
`ifdef YSYX_041514_MISALIGN_TRAP_EN
  output logic [1:0]           misalign_o,
`endif
  ysyx_041514_mem_access_if.master mem
);

  lsu_state_e           r_state;
  logic                 r_req_valid;
  logic [XLEN-1:0]      r_addr;
  logic                 r_wen;
  logic [XLEN-1:0]      r_wdata;
  logic [STRB_W-1:0]    r_wstrb;
  logic [MEMOP_LEN-1:0] r_op;
  logic [2:0]           r_off;

  logic                 w_is_op;
  logic                 w_is_store;
  logic                 w_issue;
  logic [XLEN-1:0]      w_wdata_sh;
  logic [STRB_W-1:0]    w_wstrb;
  logic [XLEN-1:0]      w_rdata_ext;

  assign w_is_op    = (mem_op_i != MEMOP_NONE);
  assign w_is_store = memop_is_store(mem_op_i);

`ifdef YSYX_041514_MISALIGN_TRAP_EN
  logic       w_mis;
  logic       w_trap;
  logic [1:0] r_misalign;
  assign w_mis      = memop_misaligned(mem_op_i, addr_i[2:0]);
  assign w_issue    = (r_state == ST_IDLE) && w_is_op && !flush_i && !w_mis;
  assign w_trap     = (r_state == ST_IDLE) && w_is_op && !flush_i && w_mis;
  assign misalign_o = r_misalign;
`else
  assign w_issue    = (r_state == ST_IDLE) && w_is_op && !flush_i;
`endif

  ysyx_041514_mem_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
    .i_st_op  (mem_op_i),
    .i_st_off (addr_i[2:0]),
    .i_wdata  (wdata_i),
    .o_wdata  (w_wdata_sh),
    .o_wstrb  (w_wstrb),
    .i_ld_op  (r_op),
    .i_ld_off (r_off),
    .i_rdata  (mem.resp_rdata),
    .o_rdata  (w_rdata_ext)
  );

  // a flush racing the handshake still owes a response, so it drains instead of idling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_op        <= MEMOP_NONE;
      r_off       <= 3'd0;
`ifdef YSYX_041514_MISALIGN_TRAP_EN
      r_misalign  <= 2'b00;
`endif
    end else begin
`ifdef YSYX_041514_MISALIGN_TRAP_EN
      r_misalign <= w_trap ? {w_is_store, ~w_is_store} : 2'b00;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
            r_addr      <= {addr_i[XLEN-1:3], 3'b000};
            r_wen       <= w_is_store;
            r_wdata     <= w_is_store ? w_wdata_sh : '0;
            r_wstrb     <= w_is_store ? w_wstrb : '0;
            r_op        <= mem_op_i;
            r_off       <= addr_i[2:0];
          end
        end
        ST_REQ: begin
          if (mem.req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= flush_i ? ST_DRAIN : ST_RESP;
          end else if (flush_i) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (mem.resp_valid) begin
            r_state <= ST_IDLE;
          end else if (flush_i) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mem.resp_valid) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_req_o = 1'b0;
    case (r_state)
      ST_IDLE:  stall_req_o = w_issue;
      ST_REQ:   stall_req_o = 1'b1;
      ST_RESP:  stall_req_o = ~mem.resp_valid;
      ST_DRAIN: stall_req_o = 1'b1;
      default:  stall_req_o = 1'b0;
    endcase
  end

  assign rdata_o = ((r_state == ST_RESP) && mem.resp_valid && !flush_i && !r_wen) ? w_rdata_ext : '0;

  assign mem.req_valid = r_req_valid;
  assign mem.req_addr  = r_addr;
  assign mem.req_wen   = r_wen;
  assign mem.req_wdata = r_wdata;
  assign mem.req_wstrb = r_wstrb;

endmodule

// File: doc/ysyx_041514_mem_access.md
Name: ysyx_041514_mem_access

Overview:
MEM-stage load/store unit that consumes the EX/MEM pipeline register outputs (mem_op, ALU address, rs2 store data).
Turns each memory op into one request/response transaction on the data-memory port.
Aligns store data and byte strobes, and extracts and extends load data.
Holds stall_req_o high until the transaction completes; the pipeline controller uses it to freeze EX/MEM and earlier stages.

Parameters:
XLEN, 64, data and address width
STRB_W, XLEN/8, byte-strobe width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush_i  in  1  discard the in-flight op (trap/redirect)
mem_op_i  in  MEMOP_LEN  op from EX/MEM; MEMOP_NONE means no access
addr_i  in  XLEN  effective address (EX/MEM alu_data)
wdata_i  in  XLEN  store data (EX/MEM rs2_data)
req_valid_o  out  1  request valid
req_ready_i  in  1  memory accepts request
req_addr_o  out  XLEN  request address, 8-byte aligned (addr_i[2:0] zeroed)
req_wen_o  out  1  1 = store
req_wdata_o  out  XLEN  lane-shifted store data
req_wstrb_o  out  STRB_W  byte strobes (0 for loads)
resp_valid_i  in  1  read data / write ack valid
resp_rdata_i  in  XLEN  raw 8-byte-aligned read data
rdata_o  out  XLEN  extended load result; valid in the completion cycle
stall_req_o  out  1  hold pipeline
misalign_o  out  2  {store, load} misaligned fault; present only with the optional feature

Behaviour:
- FSM states IDLE, REQ, RESP, DRAIN. Reset (rst=0, async): state=IDLE, req_valid_o=0, all request registers 0, rdata_o=0, misalign_o=0.
- IDLE, mem_op_i==NONE or flush_i: stall_req_o=0, no request, rdata_o=0.
- IDLE, memory op and no flush_i: stall_req_o=1 combinationally. Register addr, wen, wdata, wstrb. Next state REQ.
- REQ: req_valid_o=1. Request fields stay stable until req_ready_i. Handshake (valid&ready) moves to RESP. flush_i before the handshake returns to IDLE; no request is issued.
- RESP: stall_req_o=1 until resp_valid_i. In the resp_valid_i cycle:
  - stall_req_o=0.
  - rdata_o = extend(resp_rdata_i >> 8*addr[2:0]): B/H/W sign-extended, BU/HU/WU zero-extended, D unchanged; stores give 0.
  - Next state IDLE.
  - The EX/MEM register advances on the same edge, so the op is never re-issued.
- flush_i in RESP: go to DRAIN. DRAIN holds stall_req_o=1, discards the response and returns to IDLE on resp_valid_i. A response arriving in the flush cycle itself completes directly to IDLE with its data discarded.
- Minimum latency: 3 cycles from op visible to completion (IDLE, REQ with ready=1, RESP with resp_valid=1).
- Store lanes:
  - req_wdata_o = wdata_i << 8*addr[2:0].
  - req_wstrb_o = size mask (B=0x01, H=0x03, W=0x0F, D=0xFF) << addr[2:0], truncated to 8 bits.
  - Bytes past the 8-byte boundary are dropped.
- Only one outstanding transaction at any time.

Optional Feature:
Macro YSYX_041514_MISALIGN_TRAP_EN.
- Defined: in IDLE, an op whose addr_i is not a multiple of its access size issues no request. stall_req_o stays 0, and misalign_o pulses for one cycle: bit1 for a store, bit0 for a load. rdata_o=0. The trap unit handles the rest.
- Undefined: the misalign_o port is absent, and misaligned ops are issued with the truncated strobes described above.

Decomposition:
- Shared package/header: MEMOP_LEN; MEMOP_* encodings (NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD); access-size and signedness decode; FSM state constants.
- One sub-module, ysyx_041514_mem_align: combinational lane shift, strobe generation and load extension. The top keeps the FSM and registers.

Test Plan:
- LW addr 0x8000_0004, ready=1, resp 0x8765_4321_0000_0000 next cycle: req_addr 0x8000_0000, rdata_o=0xFFFF_FFFF_8765_4321, stall high 2 cycles.
- SB addr 0x8000_0003, wdata 0xAB, ready held 0 for 3 cycles: req_valid/addr/wstrb=0x08/wdata byte3=0xAB stable for 4 cycles; completes on ack.
- LBU addr 0x8000_0007, resp 0xF0xx..: rdata_o=0x0000_0000_0000_00F0.
- flush_i in RESP, resp 2 cycles later: stall stays 1 through DRAIN, rdata discarded, next LD issues normally.
- rst=0 asserted in REQ: req_valid_o and stall_req_o drop to 0 immediately (asynchronous); the FSM restarts in IDLE.
- MEMOP_NONE for 10 cycles: stall_req_o=0, req_valid_o=0 throughout. With the macro defined, LW at 0x…2 gives misalign_o=2'b01 for one cycle and no request.
